mem_port_arbiter: RTL and testbench

Sequential arbiter sharing the single-port unified memory between the instruction-fetch stage (read-only) and the data-memory stage (loads/stores). It sits between the pipeline and the memory macro, sequences each access over a fixed memory latency and drives stall signals back to the pipeline. Load/store size codes match the decoder's `load`/`store` encoding: 0 = word, 1 = half, 2 = byte.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (read-only) and the data-memory stage (loads/stores). Each access is
// sequenced IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> ACK, and the
// pipeline is stalled while its request is outstanding.
// Misaligned or illegal requests skip the memory and are acked directly.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (alternate the grant on ties).
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        dm_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gnt_dm_q, gnt_dm_d;   // 1 = data port owns the current access
    logic               bad_q, bad_d;         // current access is misaligned/illegal
    logic               ld_en;                // register request fields this edge
    logic               cap_en;               // capture mem_rdata this edge
    logic               pick_dm;              // arbitration result while in IDLE
    logic               dm_bad, if_bad;

    logic               we_q;
    logic [1:0]         size_q;
    logic [31:0]        addr_q, wdata_q, rdata_q;

    // Alignment rules: word needs addr[1:0]=0, half needs addr[0]=0, size 3 never legal.
    assign dm_bad = (dm_size == 2'd3) ||
                    ((dm_size == 2'd0) && (dm_addr[1:0] != 2'b00)) ||
                    ((dm_size == 2'd1) && dm_addr[0]);
    assign if_bad = (if_addr[1:0] != 2'b00);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last contested winner; only true ties update it, so a lone follow-up
    // request does not disturb the alternation between tied requesters.
    logic last_dm_q;

    // Remember which side won the most recent tie.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            last_dm_q <= 1'b0;
        else if ((state_q == S_IDLE) && dm_req && if_req)
            last_dm_q <= pick_dm;
    end

    assign pick_dm = dm_req & (~if_req | ~last_dm_q);
`else
    assign pick_dm = dm_req;
`endif

    // State register plus control fields that must clear on reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            gnt_dm_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_dm_q <= gnt_dm_d;
            bad_q    <= bad_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count latency in WAIT.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_dm_d = gnt_dm_q;
        bad_d    = bad_q;
        ld_en    = 1'b0;
        cap_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dm_req || if_req) begin
                    ld_en    = 1'b1;
                    gnt_dm_d = pick_dm;
                    bad_d    = pick_dm ? dm_bad : if_bad;
                    state_d  = (pick_dm ? dm_bad : if_bad) ? S_ACK : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LATENCY);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    cap_en  = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request fields and read data; only observed through state-gated outputs.
    always_ff @(posedge Clk) begin
        if (ld_en) begin
            we_q    <= pick_dm ? dm_we    : 1'b0;
            size_q  <= pick_dm ? dm_size  : 2'd0;
            addr_q  <= pick_dm ? dm_addr  : if_addr;
            wdata_q <= pick_dm ? dm_wdata : 32'd0;
        end
        if (cap_en)
            rdata_q <= (gnt_dm_q && we_q) ? 32'd0 : mem_rdata;
    end

    // Outputs: memory strobe in ISSUE, acks in ACK, stalls while unserved.
    always_comb begin
        mem_en    = (state_q == S_ISSUE);
        mem_we    = mem_en & we_q;
        mem_size  = mem_en ? size_q  : 2'd0;
        mem_addr  = mem_en ? addr_q  : 32'd0;
        mem_wdata = mem_en ? wdata_q : 32'd0;
        if_ack    = (state_q == S_ACK) & ~gnt_dm_q;
        dm_ack    = (state_q == S_ACK) &  gnt_dm_q;
        dm_err    = dm_ack & bad_q;
        if_rdata  = (if_ack && !bad_q) ? rdata_q : 32'd0;
        dm_rdata  = (dm_ack && !bad_q) ? rdata_q : 32'd0;
        // Reset forces every output low, including the combinational stalls.
        stall_if  = if_req & ~if_ack & ~Reset;
        stall_mem = dm_req & ~dm_ack & ~Reset;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LATENCY = 2). Expected acks and
// memory strobes are queued when a request is issued; monitors pop and compare.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [1:0]  dm_size;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, dm_err, mem_en, mem_we, stall_if, stall_mem;
    logic [1:0]  mem_size;

    mem_port_arbiter #(.MEM_LATENCY(L)) dut (
        .Clk(Clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct { bit is_dm; logic [31:0] rdata; bit err; int c; } ack_exp_t;
    typedef struct { bit we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; int c; } mem_exp_t;
    ack_exp_t ack_q[$];
    mem_exp_t mem_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2002000A : (a ^ 32'h5A5A0000);
    endfunction

    // Memory model: read data valid only in cycle issue+L, garbage otherwise.
    initial begin : mem_model
        int iss;
        bit have;
        logic [31:0] a;
        iss = 0; have = 0; a = '0;
        mem_rdata = 32'hDEADBEEF;
        forever begin
            @(negedge Clk);
            if (mem_en) begin
                have = 1; iss = cyc; a = mem_addr;
            end
            mem_rdata = (have && cyc == iss + L) ? mem_val(a) : 32'hDEADBEEF;
        end
    end

    // Ack monitor.
    initial begin : ack_mon
        ack_exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset && (if_ack || dm_ack)) begin
                if (ack_q.size() == 0) begin
                    chk("spurious_ack", {30'd0, dm_ack, if_ack}, 32'd0);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_port_dm", {31'd0, dm_ack}, {31'd0, e.is_dm});
                    chk("ack_port_if", {31'd0, if_ack}, {31'd0, ~e.is_dm});
                    chk("ack_cycle", cyc, e.c);
                    if (e.is_dm) begin
                        chk("dm_rdata", dm_rdata, e.rdata);
                        chk("dm_err", {31'd0, dm_err}, {31'd0, e.err});
                    end else begin
                        chk("if_rdata", if_rdata, e.rdata);
                    end
                end
            end
        end
    end

    // Memory strobe monitor.
    initial begin : mem_mon
        mem_exp_t m;
        forever begin
            @(negedge Clk);
            if (!Reset && mem_en) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_en", {31'd0, mem_en}, 32'd0);
                end else begin
                    m = mem_q.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                    chk("mem_size", {30'd0, mem_size}, {30'd0, m.size});
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_wdata", mem_wdata, m.wdata);
                    chk("mem_cycle", cyc, m.c);
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_ack(input bit d, input logic [31:0] r, input bit e, input int c);
        ack_exp_t x;
        x.is_dm = d; x.rdata = r; x.err = e; x.c = c;
        ack_q.push_back(x);
    endtask

    task automatic push_mem(input bit we, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input int c);
        mem_exp_t x;
        x.we = we; x.size = sz; x.addr = a; x.wdata = wd; x.c = c;
        mem_q.push_back(x);
    endtask

    // Act as both requesters: hold req until its ack, drop it the cycle after.
    task automatic serve(input int budget);
        int n;
        bit ia, da;
        n = 0;
        while ((if_req || dm_req) && n < budget) begin
            @(negedge Clk);
            ia = if_ack; da = dm_ack;
            step();
            if (ia) if_req = 1'b0;
            if (da) dm_req = 1'b0;
            n++;
        end
        if (if_req || dm_req) begin
            chk("serve_timeout", {30'd0, dm_req, if_req}, 32'd0);
            if_req = 1'b0; dm_req = 1'b0;
        end
    endtask

    task automatic dm_issue(input bit we, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
        dm_req = 1'b1; dm_we = we; dm_size = sz; dm_addr = a; dm_wdata = wd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_if_ack"}, {31'd0, if_ack}, 32'd0);
        chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
        chk({tag, "_dm_ack"}, {31'd0, dm_ack}, 32'd0);
        chk({tag, "_dm_err"}, {31'd0, dm_err}, 32'd0);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_size"}, {30'd0, mem_size}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_stall_if"}, {31'd0, stall_if}, 32'd0);
        chk({tag, "_stall_mem"}, {31'd0, stall_mem}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t, t2;
        Reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = '0; dm_addr = '0; dm_wdata = '0;
        step();
        // Requests held during reset must not show up as stalls.
        if_req = 1'b1; if_addr = 32'h40;
        dm_issue(1'b0, 2'd0, 32'h100, 32'd0);
        @(negedge Clk);
        chk_all_zero("reset");
        step();
        if_req = 1'b0; dm_req = 1'b0;
        Reset = 1'b0;
        step();

        // Aligned fetch from 0x40, stall high t..t+3.
        t = cyc;
        if_req = 1'b1; if_addr = 32'h40;
        push_mem(1'b0, 2'd0, 32'h40, 32'd0, t + 1);
        push_ack(1'b0, 32'h2002000A, 1'b0, t + 4);
        for (int k = 0; k <= 4; k++) begin
            @(negedge Clk);
            chk("stall_if", {31'd0, stall_if}, (k < 4) ? 32'd1 : 32'd0);
            step();
        end
        if_req = 1'b0;

        // Two ties of fetch 0x80 vs word load 0x100.
        for (int tie = 0; tie < 2; tie++) begin
            bit dm_first;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            dm_first = (tie == 0);
`else
            dm_first = 1'b1;
`endif
            t = cyc;
            if_req = 1'b1; if_addr = 32'h80;
            dm_issue(1'b0, 2'd0, 32'h100, 32'd0);
            if (dm_first) begin
                push_mem(1'b0, 2'd0, 32'h100, 32'd0, t + 1);
                push_ack(1'b1, 32'h5A5A0100, 1'b0, t + 4);
                push_mem(1'b0, 2'd0, 32'h80, 32'd0, t + 6);
                push_ack(1'b0, 32'h5A5A0080, 1'b0, t + 9);
            end else begin
                push_mem(1'b0, 2'd0, 32'h80, 32'd0, t + 1);
                push_ack(1'b0, 32'h5A5A0080, 1'b0, t + 4);
                push_mem(1'b0, 2'd0, 32'h100, 32'd0, t + 6);
                push_ack(1'b1, 32'h5A5A0100, 1'b0, t + 9);
            end
            serve(30);
        end

        // Misaligned / illegal requests: acked next cycle, no memory strobe.
        t = cyc; dm_issue(1'b0, 2'd1, 32'h103, 32'd0);
        push_ack(1'b1, 32'd0, 1'b1, t + 1); serve(10);
        t = cyc; dm_issue(1'b0, 2'd0, 32'h102, 32'd0);
        push_ack(1'b1, 32'd0, 1'b1, t + 1); serve(10);
        t = cyc; dm_issue(1'b1, 2'd3, 32'h200, 32'h55);
        push_ack(1'b1, 32'd0, 1'b1, t + 1); serve(10);
        t = cyc; if_req = 1'b1; if_addr = 32'h42;
        push_ack(1'b0, 32'd0, 1'b0, t + 1); serve(10);

        // Byte store 0xAB to 0x201, then aligned half store.
        t = cyc; dm_issue(1'b1, 2'd2, 32'h201, 32'hAB);
        push_mem(1'b1, 2'd2, 32'h201, 32'hAB, t + 1);
        push_ack(1'b1, 32'd0, 1'b0, t + 4);
        @(negedge Clk);
        chk("stall_mem", {31'd0, stall_mem}, 32'd1);
        serve(20);
        t = cyc; dm_issue(1'b1, 2'd1, 32'h302, 32'hBEEF);
        push_mem(1'b1, 2'd1, 32'h302, 32'hBEEF, t + 1);
        push_ack(1'b1, 32'd0, 1'b0, t + 4);
        serve(20);

        // Reset during WAIT abandons the access; held request reissues.
        t = cyc; dm_issue(1'b0, 2'd0, 32'h400, 32'd0);
        push_mem(1'b0, 2'd0, 32'h400, 32'd0, t + 1);
        step(); step();
        Reset = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        step();
        Reset = 1'b0;
        t2 = cyc;
        push_mem(1'b0, 2'd0, 32'h400, 32'd0, t2 + 1);
        push_ack(1'b1, 32'h5A5A0400, 1'b0, t2 + 4);
        serve(20);

        repeat (6) step();
        chk("ack_queue_drained", ack_q.size(), 32'd0);
        chk("mem_queue_drained", mem_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
